// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async FIFO read-side packer.
package async_fifo_pkg;

  // Packer control state: RUN packs normally, FLUSH waits for the FIFO to
  // drain and then emits whatever lanes are held as a partial beat.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rd_pack_state_e;

  // Default number of FIFO words packed into one output beat.
  localparam int unsigned RD_PACK_RATIO_DEFAULT = 4;

  // Widest lane mask lane_mask() can produce; RATIO must not exceed this.
  localparam int unsigned RD_PACK_MAX_LANES = 64;

  // Bit i is set for every lane index i < n. Used to zero-fill the lanes of a
  // partial beat that were not written since the last emitted beat.
  function automatic logic [RD_PACK_MAX_LANES-1:0] lane_mask(input int unsigned n);
    logic [RD_PACK_MAX_LANES-1:0] m;
    for (int unsigned i = 0; i < RD_PACK_MAX_LANES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/rd_pack_outreg.sv
// Output beat register of the read-side packer: a single-entry valid/ready
// stage that loads a new beat, holds it under backpressure and drains it on
// acceptance. A load and a drain in the same cycle keep valid high.
module rd_pack_outreg #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [CW-1:0] load_cnt,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_cnt,
  output logic          out_free
);

  logic          valid_q, valid_d;
  logic [W-1:0]  data_q,  data_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // The register can take a new beat when it is empty or being drained now.
  assign out_free  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;

  // Next-state: load wins over drain; otherwise data/cnt hold unchanged.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      cnt_d   = load_cnt;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/async_fifo_rd_packer.sv
// Read-side consumer of the async FIFO (rclk domain). Pops show-ahead words
// whenever the FIFO is non-empty and there is room, packs RATIO words LSB-first
// into one output beat, and on a flush request emits the held lanes as a
// zero-filled partial beat once the FIFO has drained.
module async_fifo_rd_packer
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned RATIO = RD_PACK_RATIO_DEFAULT,
  parameter int unsigned CW    = $clog2(RATIO + 1)
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RATIO*DSIZE-1:0] out_data,
  output logic [CW-1:0]          out_cnt,
  output logic                   busy
);

  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);

  rd_pack_state_e                  state_q, state_d;
  logic [CW-1:0]                   cnt_q,   cnt_d;
  logic [RATIO-2:0][DSIZE-1:0]     acc_q,   acc_d;

  logic                            out_free;
  logic                            flush_emit;
  logic                            pop;
  logic                            full_load;
  logic                            load;
  logic [RATIO*DSIZE-1:0]          load_data;
  logic [CW-1:0]                   load_cnt;
  logic [RATIO-2:0]                lane_en;

  // Partial beat goes out only once the FIFO is empty, so any word that
  // arrives during FLUSH is packed first.
  assign flush_emit = (state_q == FLUSH) && rempty && (cnt_q != '0) && out_free;

  // The last lane of a beat can only be popped if the output register can
  // take the completed beat this cycle (combinational out_ready -> rinc).
  assign pop       = !rrst && !rempty && ((cnt_q != CNT_LAST) || out_free) && !flush_emit;
  assign full_load = pop && (cnt_q == CNT_LAST);
  assign load      = full_load || flush_emit;
  assign rinc      = pop;
  assign busy      = (cnt_q != '0) || (state_q == FLUSH);

  // Beat assembly: full beat takes the live word as the top lane; a flush
  // beat keeps only lanes written since the last beat, zero-filling the rest.
  always_comb begin
    lane_en   = (RATIO - 1)'(lane_mask(32'(cnt_q)));
    load_data = '0;
    load_cnt  = cnt_q;
    if (full_load) begin
      load_data = {rdata, acc_q};
      load_cnt  = CNT_FULL;
    end else begin
      for (int unsigned i = 0; i < RATIO - 1; i++) begin
        if (lane_en[i]) begin
          load_data[i*DSIZE +: DSIZE] = acc_q[i];
        end
      end
    end
  end

  // Lane accumulator, lane index and flush FSM next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    if (pop) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        for (int unsigned i = 0; i < RATIO - 1; i++) begin
          if (cnt_q == CW'(i)) begin
            acc_d[i] = rdata;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (flush_emit) begin
      cnt_d = '0;
    end

    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Leave once drained: either nothing was held or the partial beat
        // is being emitted now. A repeated flush here is simply ignored.
        if (rempty && ((cnt_q == '0) || flush_emit)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Packer state registers; reset discards any held lanes.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  rd_pack_outreg #(
    .W  (RATIO * DSIZE),
    .CW (CW)
  ) u_outreg (
    .clk       (rclk),
    .rst       (rrst),
    .load      (load),
    .load_data (load_data),
    .load_cnt  (load_cnt),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_free  (out_free)
  );

endmodule
